// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : cpu_pkg                                                    |
// | Shared CPU constants, fetch buffer entry type and helpers used by   |
// | fetch and decode.                                                    |
// | Revision: 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Major opcodes shared with decode / immediate generation.
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Drop the byte offset so every fetch address is word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : fetch_unit_if                                            |
// | Instruction-memory request/response, redirect and decode-side       |
// | handshake signals of the fetch stage.                               |
// | Revision: 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface fetch_unit_if;
  import cpu_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc;

  // Fetch stage side.
  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, out_ready
  );

  // Memory / decode / branch-resolution side.
  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, out_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fetch_fifo                                                  |
// | In-order {pc, inst} buffer. No bypass; flush overrides push/pop.    |
// | Revision: 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [IW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (p == IW'(DEPTH - 1)) ? '0 : p + IW'(1);
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_q];

  // A push at full is only taken when a pop frees the head slot the same cycle.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_data;
        wr_d        = ptr_inc(wr_q);
      end
      if (do_pop) begin
        rd_d = ptr_inc(rd_q);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer/count registers; storage needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end
endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fetch_unit                                                  |
// | Owns the fetch PC, issues credit-limited word requests, buffers     |
// | responses in order and hands {pc, inst} to decode. Redirect flushes |
// | the buffer and drops responses already in flight.                   |
// | Revision: 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;
  fetch_entry_t    fifo_head, push_entry;
  logic [CW:0]     inflight;
  logic            req_valid, accept, resp_push, out_pop, head_valid;

  // Credit: words requested but not yet returned plus words buffered.
  assign inflight   = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign req_valid  = !rst && !bus.redirect_valid && (inflight < DEPTH_W);
  assign accept     = req_valid && bus.imem_req_ready;
  assign resp_push  = bus.imem_resp_valid && !bus.redirect_valid && (drop_q == '0);
  assign head_valid = !rst && !fifo_empty;
  assign out_pop    = head_valid && bus.out_ready && !bus.redirect_valid;
  assign push_entry = '{pc: resp_pc_q, inst: bus.imem_resp_data};

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.out_valid      = head_valid;
  assign bus.out_inst       = head_valid ? fifo_head.inst : INST_NOP;
  assign bus.out_pc         = head_valid ? fifo_head.pc   : '0;

  // Next PC / credit / drop accounting; a redirect overrides everything else.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (bus.redirect_valid) begin
      fetch_pc_d    = word_align(bus.redirect_pc);
      resp_pc_d     = word_align(bus.redirect_pc);
      outstanding_d = outstanding_q - CW'(bus.imem_resp_valid);
      drop_d        = outstanding_q - CW'(bus.imem_resp_valid);
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      outstanding_d = outstanding_q + CW'(accept) - CW'(bus.imem_resp_valid);
      if (bus.imem_resp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else begin
          resp_pc_d = resp_pc_q + 32'd4;
        end
      end
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  // Credit accounting means a response never lands on a full buffer without a pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(resp_push && fifo_full && !out_pop));
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (resp_push),
    .push_data (push_entry),
    .pop       (out_pop),
    .flush     (bus.redirect_valid),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_fetch_unit                                               |
// | Scoreboard bench: fixed-latency memory model, expected {pc,inst}    |
// | queue filled by directed stimulus, monitor compares every pop.      |
// | Revision: 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_fetch_unit;
  typedef struct {
    int          due;
    logic [31:0] data;
  } mem_rsp_t;

  logic        clk;
  logic        rst;
  logic        want_ready, force_ready, ready_auto;
  int          cyc;
  int          lat;
  int          tests;
  int          fails;
  logic [31:0] exp_q[$];
  logic [31:0] req_log[$];
  int          pop_cyc[$];
  mem_rsp_t    pend[$];

  fetch_unit_if bus();

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.out_ready = force_ready | ready_auto;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0013;
  endfunction

  function automatic logic [31:0] log_at(input int k);
    return (k < req_log.size()) ? req_log[k] : 32'hBAD0_BAD0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Memory model: in-order responses 'lat' cycles after acceptance.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pend.delete();
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = pend[0].data;
      pend.delete(0);
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
    end
    ready_auto = want_ready && (exp_q.size() != 0);
    #2;
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      pend.push_back('{due: cyc + lat, data: inst_of(bus.imem_req_addr)});
      req_log.push_back(bus.imem_req_addr);
    end
  end

  // Monitor: every consumed output is checked against the scoreboard.
  always @(negedge clk) begin
    logic [31:0] e;
    #3;
    if (!rst && bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: got pc %h expected none", bus.out_pc);
      end else begin
        e = exp_q.pop_front();
        check("out_pc", bus.out_pc, e);
        check("out_inst", bus.out_inst, inst_of(e));
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    want_ready  = 1'b0;
    force_ready = 1'b0;
    tick();
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    check("rst_out_inst", bus.out_inst, 32'h0000_0013);
    check("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
    tick();
    exp_q.delete();
    req_log.delete();
    pop_cyc.delete();
    rst = 1'b0;
    #0;
    check("post_rst_empty", {31'b0, bus.out_valid}, 32'h0);
    check("post_rst_addr", bus.imem_req_addr, 32'h0);
  endtask

  task automatic wait_empty(input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) tick();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d left expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_log(input int n, input int bound);
    for (int i = 0; i < bound && req_log.size() < n; i++) tick();
    tests++;
    if (req_log.size() < n) begin
      fails++;
      $display("FAIL req_timeout: got %0d expected %0d", req_log.size(), n);
    end
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; lat = 1;
    rst = 1'b1;
    want_ready = 1'b0; force_ready = 1'b0; ready_auto = 1'b0;
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;

    // Streaming with 1-cycle memory.
    do_reset();
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    want_ready = 1'b1;
    wait_empty(40);
    check("stream_req0", log_at(0), 32'h0);
    check("stream_req1", log_at(1), 32'h4);
    check("stream_req2", log_at(2), 32'h8);
    check("stream_b2b", (pop_cyc.size() > 1) ? pop_cyc[1] - pop_cyc[0] : -1, 32'd1);

    // Decode stalled: credit stops at DEPTH, then drains in order.
    do_reset();
    repeat (8) tick();
    check("stall_req_cnt", req_log.size(), 32'd2);
    check("stall_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
    check("stall_out_valid", {31'b0, bus.out_valid}, 32'h1);
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    want_ready = 1'b1;
    wait_empty(40);
    check("stall_resume", log_at(2), 32'h8);

    // Memory not ready: address held.
    do_reset();
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    want_ready = 1'b1;
    wait_log(2, 20);
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_addr", bus.imem_req_addr, 32'h8);
    end
    check("hold_valid", {31'b0, bus.imem_req_valid}, 32'h1);
    check("hold_no_accept", req_log.size(), 32'd2);
    bus.imem_req_ready = 1'b1;
    wait_empty(40);
    check("hold_resume", log_at(2), 32'h8);

    // Redirect with two responses in flight (3-cycle memory).
    do_reset();
    lat = 3;
    wait_log(2, 20);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    tick();
    bus.redirect_valid = 1'b0;
    check("redir_drop", 32'(dut.drop_q), 32'd2);
    check("redir_outst", 32'(dut.outstanding_q), 32'd2);
    exp_q = '{32'h100, 32'h104, 32'h108};
    want_ready = 1'b1;
    wait_empty(60);
    check("redir_req", log_at(2), 32'h100);
    check("redir_req_next", log_at(3), 32'h104);

    // Redirect in the same cycle as a response and a pop.
    do_reset();
    lat = 2;
    for (int i = 0; i < 20 && !(bus.out_valid && bus.imem_resp_valid); i++) tick();
    check("coll_setup", {30'b0, bus.out_valid, bus.imem_resp_valid}, 32'h3);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    force_ready        = 1'b1;
    #0;
    check("coll_no_req", {31'b0, bus.imem_req_valid}, 32'h0);
    tick();
    bus.redirect_valid = 1'b0;
    force_ready        = 1'b0;
    check("coll_flushed", {31'b0, bus.out_valid}, 32'h0);
    check("coll_drop", 32'(dut.drop_q), 32'(dut.outstanding_q));
    check("coll_outst", 32'(dut.outstanding_q), 32'd0);
    exp_q = '{32'h200, 32'h204};
    want_ready = 1'b1;
    wait_empty(40);
    check("coll_req", log_at(2), 32'h200);

    // Redirect to the top word: PC wraps to zero.
    do_reset();
    lat = 1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFF;
    tick();
    bus.redirect_valid = 1'b0;
    exp_q = '{32'hFFFF_FFFC, 32'h0, 32'h4};
    want_ready = 1'b1;
    wait_empty(40);
    check("wrap_req0", log_at(0), 32'hFFFF_FFFC);
    check("wrap_req1", log_at(1), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of decode/immediate generation. It owns the PC, issues word requests to instruction memory over a valid/ready handshake, and buffers returned words in a small in-order queue. It presents {pc, inst} pairs to decode over a valid/ready handshake. On redirect (branch/jal/jalr resolved downstream) it flushes its buffer and discards responses already in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded at reset; bits [1:0] must be 0.
DEPTH, 2, instruction buffer entries and maximum outstanding-plus-buffered words; legal 1..8.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
imem_req_valid  output  1  request to fetch the word at imem_req_addr.
imem_req_ready  input  1  memory accepts the request this cycle.
imem_req_addr  output  32  byte address, always word aligned; equals the current fetch PC.
imem_resp_valid  input  1  response word valid; responses return in request order, at least 1 cycle after acceptance.
imem_resp_data  input  32  instruction word.
redirect_valid  input  1  redirect fetch to redirect_pc this cycle.
redirect_pc  input  32  new PC; bits [1:0] ignored and forced to 0.
out_valid  output  1  buffer head is valid.
out_ready  input  1  decode consumes the head this cycle.
out_inst  output  32  instruction at buffer head; 32'h0000_0013 (nop) when out_valid=0.
out_pc  output  32  PC of the instruction at buffer head; 0 when out_valid=0.

Behaviour:
- Reset (rst=1 at edge): fetch_pc=RESET_PC; buffer empty; outstanding=0; drop=0. While rst=1, imem_req_valid=0 and out_valid=0. First request is possible in the first cycle with rst=0.
- Request rule: imem_req_valid = !rst && !redirect_valid && (outstanding + count < DEPTH). Accept = imem_req_valid && imem_req_ready. On accept: fetch_pc += 4 (32-bit wrap, 32'hFFFF_FFFC -> 0) and outstanding += 1. imem_req_addr must stay stable while imem_req_valid=1 and ready=0.
- Response: when imem_resp_valid=1 and drop>0, discard the word; drop -= 1, outstanding -= 1. Otherwise push {pc_of_response, data} into the buffer; outstanding -= 1. pc_of_response comes from an internal response-PC register advanced by 4 per response. Buffer overflow is impossible by the credit rule.
- Output: out_valid = count != 0. Pop on out_valid && out_ready. Push and pop in the same cycle are legal, including at full (count==DEPTH) and at empty with bypass disabled: a response appears on the output one cycle after arrival at the earliest.
- Redirect (redirect_valid=1): at the edge, fetch_pc and the response-PC register become {redirect_pc[31:2],2'b00}; buffer is flushed (count=0). drop becomes the number of responses still outstanding after this cycle's response, i.e. outstanding minus (imem_resp_valid ? 1 : 0). Any response in the redirect cycle is discarded. Any pop that cycle is ignored; redirect wins. No request is issued in the redirect cycle.
- Back-to-back redirects: the last one wins; drop is recomputed each time.
- Counters are clog2(DEPTH+1) bits wide; outstanding+count never exceeds DEPTH.
- Reset asserted mid-operation clears everything. Responses still returning from memory after reset are the memory's responsibility: the memory is reset together with this block.

Decomposition:
- Shared package cpu_pkg: XLEN=32, INST_NOP=32'h0000_0013, RESET_PC default, opcode constants shared with decode.
- One sub-module: fetch_fifo, a synchronous FIFO holding {pc, inst} with push, pop, flush, count, and full/empty. It has no bypass, and flush overrides push and pop.

Test Plan:
- Reset, 1-cycle memory, out_ready=1 -> requests at 0x0, 0x4, 0x8…; out_pc 0x0 then 0x4 on consecutive cycles with matching out_inst; during rst, out_valid=0 and out_inst=0x13.
- out_ready=0, DEPTH=2 -> exactly 2 requests accepted, then imem_req_valid=0. Raise out_ready -> the 0x0 and 0x4 words drain in order, and fetching resumes at 0x8.
- imem_req_ready held 0 for 3 cycles -> imem_req_addr is held at 0x8, no PC advance.
- 2 requests in flight with 3-cycle memory, redirect_pc=0x103 -> both stale responses are dropped, the next request is at 0x100, and the first output is out_pc=0x100.
- Redirect in the same cycle as a response and a pop -> the response and pop are discarded, the buffer is empty next cycle, and drop equals the remaining outstanding count.
- Redirect to 0xFFFF_FFFC -> the following requests are at 0xFFFF_FFFC and then 0x0.
